// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy path.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } t_rd_burst_state;

  localparam int DMA_PAGE_BYTES = 4096;

endpackage

// File: rtl/dma_rd_burst_gen.sv
// Read-side address stage: splits one descriptor into page-safe AR bursts,
// throttles outstanding bursts on R last beats and pulses done when all data returned.
module dma_rd_burst_gen
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_BYTES         = 64,
  parameter int MAX_BURST_BEATS    = 64,
  parameter int PAGE_BYTES         = DMA_PAGE_BYTES,
  parameter int MAX_REQS_IN_FLIGHT = 32,
  parameter int LEN_WIDTH          = 32,
  parameter int ID_WIDTH           = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      desc_valid,
  output logic                                      desc_ready,
  input  logic [ADDR_WIDTH-1:0]                     desc_src_addr,
  input  logic [LEN_WIDTH-1:0]                      desc_len_bytes,
  output logic                                      arvalid,
  input  logic                                      arready,
  output logic [ADDR_WIDTH-1:0]                     araddr,
  output logic [7:0]                                arlen,
  output logic [ID_WIDTH-1:0]                       arid,
  input  logic                                      r_last_fire,
  output logic [$clog2(MAX_REQS_IN_FLIGHT+1)-1:0]   inflight,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_underflow
);

  localparam int DB_LOG     = $clog2(DATA_BYTES);
  localparam int PG_LOG     = $clog2(PAGE_BYTES);
  localparam int BEATS_W    = LEN_WIDTH - DB_LOG;
  localparam int BURST_W    = $clog2(MAX_BURST_BEATS) + 1;
  localparam int PG_BEATS_W = PG_LOG - DB_LOG + 1;
  localparam int INF_W      = $clog2(MAX_REQS_IN_FLIGHT + 1);

  t_rd_burst_state        state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BEATS_W-1:0]     beats_left_q;
  logic [BURST_W-1:0]     burst_beats_q;
  logic [BURST_W-1:0]     burst_beats_d;
  logic [INF_W-1:0]       inflight_q;
  logic [INF_W-1:0]       inflight_d;
  logic                   arvalid_q;
  logic [ADDR_WIDTH-1:0]  araddr_q;
  logic [7:0]             arlen_q;
  logic [ID_WIDTH-1:0]    arid_q;
  logic                   desc_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_underflow_q;
  logic                   rlast_mask_q;

  logic [PG_BEATS_W-1:0]  page_room_s;
  logic [BEATS_W-1:0]     cap_s;
  logic                   ar_fire_s;
  logic                   rlast_s;
  logic                   underflow_s;
  logic                   unused_len_bits_s;

  assign unused_len_bits_s = ^desc_len_bytes[DB_LOG-1:0];

  // Burst size: smallest of remaining beats, max burst and beats left in the current page.
  always_comb begin
    page_room_s   = PG_BEATS_W'(PAGE_BYTES >> DB_LOG) - PG_BEATS_W'(addr_q[PG_LOG-1:DB_LOG]);
    cap_s         = BEATS_W'(MAX_BURST_BEATS);
    burst_beats_d = {BURST_W{1'b0}};
    if (BEATS_W'(page_room_s) < cap_s) begin
      cap_s = BEATS_W'(page_room_s);
    end else begin
      cap_s = BEATS_W'(MAX_BURST_BEATS);
    end
    if (beats_left_q < cap_s) begin
      burst_beats_d = BURST_W'(beats_left_q);
    end else begin
      burst_beats_d = BURST_W'(cap_s);
    end
  end

  // Credit counter: AR handshakes add, unmasked R last beats retire; both together cancel.
  always_comb begin
    ar_fire_s   = arvalid_q & arready;
    rlast_s     = r_last_fire & ~rlast_mask_q;
    underflow_s = 1'b0;
    inflight_d  = inflight_q;
    if (ar_fire_s && !rlast_s) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!ar_fire_s && rlast_s) begin
      if (inflight_q == {INF_W{1'b0}}) begin
        underflow_s = 1'b1;
      end else begin
        inflight_d = inflight_q - INF_W'(1);
      end
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Main FSM with all outputs registered; rlast is masked after reset until a new descriptor.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= {ADDR_WIDTH{1'b0}};
      beats_left_q    <= {BEATS_W{1'b0}};
      burst_beats_q   <= {BURST_W{1'b0}};
      inflight_q      <= {INF_W{1'b0}};
      arvalid_q       <= 1'b0;
      araddr_q        <= {ADDR_WIDTH{1'b0}};
      arlen_q         <= 8'd0;
      arid_q          <= {ID_WIDTH{1'b0}};
      desc_ready_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_underflow_q <= 1'b0;
      rlast_mask_q    <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      if (underflow_s) begin
        err_underflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (desc_valid && desc_ready_q) begin
            addr_q       <= desc_src_addr;
            beats_left_q <= desc_len_bytes[LEN_WIDTH-1:DB_LOG];
            busy_q       <= 1'b1;
            desc_ready_q <= 1'b0;
            rlast_mask_q <= 1'b0;
            state_q      <= CALC;
          end else begin
            desc_ready_q <= 1'b1;
          end
        end
        CALC: begin
          if (beats_left_q == {BEATS_W{1'b0}}) begin
            state_q <= DRAIN;
            done_q  <= (inflight_d == {INF_W{1'b0}});
          end else if (inflight_q < INF_W'(MAX_REQS_IN_FLIGHT)) begin
            araddr_q      <= addr_q;
            arlen_q       <= 8'(burst_beats_d - BURST_W'(1));
            burst_beats_q <= burst_beats_d;
            arvalid_q     <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (arready) begin
            arvalid_q    <= 1'b0;
            addr_q       <= addr_q + (ADDR_WIDTH'(burst_beats_q) << DB_LOG);
            beats_left_q <= beats_left_q - BEATS_W'(burst_beats_q);
            arid_q       <= arid_q + ID_WIDTH'(1);
            if (beats_left_q == BEATS_W'(burst_beats_q)) begin
              state_q <= DRAIN;
              done_q  <= (inflight_d == {INF_W{1'b0}});
            end else begin
              state_q <= CALC;
            end
          end
        end
        DRAIN: begin
          // done_q is already high in the cycle inflight first reads zero.
          if (inflight_q == {INF_W{1'b0}}) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            desc_ready_q <= 1'b1;
          end else begin
            done_q <= (inflight_d == {INF_W{1'b0}});
          end
        end
        default: begin
          state_q      <= IDLE;
          arvalid_q    <= 1'b0;
          busy_q       <= 1'b0;
          desc_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign desc_ready    = desc_ready_q;
  assign arvalid       = arvalid_q;
  assign araddr        = araddr_q;
  assign arlen         = arlen_q;
  assign arid          = arid_q;
  assign inflight      = inflight_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_dma_rd_burst_gen.sv
// Directed self-checking bench for dma_rd_burst_gen (64B beats, 64-beat bursts, 4 KiB pages, 2 credits).
module tb_dma_rd_burst_gen;

  logic        clk;
  logic        reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_src_addr;
  logic [31:0] desc_len_bytes;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic        r_last_fire;
  logic [1:0]  inflight;
  logic        busy;
  logic        done;
  logic        err_underflow;

  int          n_checks;
  int          n_fail;
  logic [3:0]  exp_arid;

  dma_rd_burst_gen #(
    .ADDR_WIDTH         (64),
    .DATA_BYTES         (64),
    .MAX_BURST_BEATS    (64),
    .PAGE_BYTES         (4096),
    .MAX_REQS_IN_FLIGHT (2),
    .LEN_WIDTH          (32),
    .ID_WIDTH           (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_src_addr  (desc_src_addr),
    .desc_len_bytes (desc_len_bytes),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .arlen          (arlen),
    .arid           (arid),
    .r_last_fire    (r_last_fire),
    .inflight       (inflight),
    .busy           (busy),
    .done           (done),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] a, input logic [31:0] l);
    desc_src_addr  = a;
    desc_len_bytes = l;
    desc_valid     = 1'b1;
    step();
    desc_valid     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_checks++;
    if ({desc_ready, arvalid, busy, done, err_underflow} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/arv/busy/done/err=%b required 00000",
               {desc_ready, arvalid, busy, done, err_underflow});
    end
    n_checks++;
    if ({araddr, arlen, arid, inflight} !== 78'd0) begin
      n_fail++;
      $display("FAIL reset_data: got araddr=%h arlen=%0d arid=%0d inflight=%0d required all 0",
               araddr, arlen, arid, inflight);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if ({desc_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got rdy/busy=%b required 10", {desc_ready, busy});
    end
  endtask

  // Two-burst descriptor with arready held high and both R last beats returned at the end.
  task automatic run_two_burst(input string name, input logic [63:0] a, input logic [31:0] l,
                               input logic [63:0] a0, input logic [7:0] l0,
                               input logic [63:0] a1, input logic [7:0] l1);
    logic [63:0] ea [2];
    logic [7:0]  el [2];
    ea[0] = a0; ea[1] = a1;
    el[0] = l0; el[1] = l1;
    arready = 1'b1;
    accept(a, l);
    n_checks++;
    if ({arvalid, busy, desc_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s_calc: got arv/busy/rdy=%b required 010", name, {arvalid, busy, desc_ready});
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({arvalid, araddr, arlen, arid} !== {1'b1, ea[k], el[k], exp_arid}) begin
        n_fail++;
        $display("FAIL %s_ar%0d: got v=%b addr=%h len=%0d id=%0d required v=1 addr=%h len=%0d id=%0d",
                 name, k, arvalid, araddr, arlen, arid, ea[k], el[k], exp_arid);
      end
      step();
      exp_arid = exp_arid + 4'd1;
      n_checks++;
      if ({arvalid, inflight} !== {1'b0, 2'(k + 1)}) begin
        n_fail++;
        $display("FAIL %s_post%0d: got arv=%b inflight=%0d required arv=0 inflight=%0d",
                 name, k, arvalid, inflight, k + 1);
      end
    end
    r_last_fire = 1'b1;
    step();
    n_checks++;
    if ({inflight, done} !== {2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_rlast1: got inflight=%0d done=%b required 1/0", name, inflight, done);
    end
    step();
    r_last_fire = 1'b0;
    n_checks++;
    if ({inflight, done, busy} !== {2'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_done: got inflight=%0d done=%b busy=%b required 0/1/1", name, inflight, done, busy);
    end
    step();
    n_checks++;
    if ({done, busy, desc_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_idle: got done/busy/rdy=%b required 001", name, {done, busy, desc_ready});
    end
  endtask

  task automatic test_zero_len();
    accept(64'h0000_0000_0000_3000, 32'd0);
    n_checks++;
    if ({arvalid, done, inflight} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_calc: got arv=%b done=%b inflight=%0d required 0/0/0", arvalid, done, inflight);
    end
    step();
    n_checks++;
    if ({arvalid, done, busy, inflight} !== {3'b011, 2'd0}) begin
      n_fail++;
      $display("FAIL zero_done: got arv=%b done=%b busy=%b inflight=%0d required 0/1/1/0",
               arvalid, done, busy, inflight);
    end
    step();
    n_checks++;
    if ({done, busy, desc_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL zero_idle: got done/busy/rdy=%b required 001", {done, busy, desc_ready});
    end
  endtask

  task automatic test_credit_limit();
    arready = 1'b1;
    accept(64'h0, 32'd16384);
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({arvalid, araddr, arlen} !== {1'b1, 64'(k) * 64'h1000, 8'd63}) begin
        n_fail++;
        $display("FAIL credit_ar%0d: got v=%b addr=%h len=%0d required v=1 addr=%h len=63",
                 k, arvalid, araddr, arlen, 64'(k) * 64'h1000);
      end
      step();
      exp_arid = exp_arid + 4'd1;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if ({arvalid, inflight} !== {1'b0, 2'd2}) begin
        n_fail++;
        $display("FAIL credit_stall%0d: got arv=%b inflight=%0d required 0/2", k, arvalid, inflight);
      end
    end
    for (int k = 2; k < 4; k++) begin
      r_last_fire = 1'b1;
      step();
      r_last_fire = 1'b0;
      n_checks++;
      if ({arvalid, inflight} !== {1'b0, 2'd1}) begin
        n_fail++;
        $display("FAIL credit_ret%0d: got arv=%b inflight=%0d required 0/1", k, arvalid, inflight);
      end
      step();
      n_checks++;
      if ({arvalid, araddr, arlen, arid} !== {1'b1, 64'(k) * 64'h1000, 8'd63, exp_arid}) begin
        n_fail++;
        $display("FAIL credit_ar%0d: got v=%b addr=%h len=%0d id=%0d required v=1 addr=%h len=63 id=%0d",
                 k, arvalid, araddr, arlen, arid, 64'(k) * 64'h1000, exp_arid);
      end
      step();
      exp_arid = exp_arid + 4'd1;
      n_checks++;
      if ({arvalid, inflight} !== {1'b0, 2'd2}) begin
        n_fail++;
        $display("FAIL credit_full%0d: got arv=%b inflight=%0d required 0/2", k, arvalid, inflight);
      end
    end
    r_last_fire = 1'b1;
    step();
    step();
    r_last_fire = 1'b0;
    n_checks++;
    if ({done, inflight} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL credit_done: got done=%b inflight=%0d required 1/0", done, inflight);
    end
    step();
  endtask

  task automatic test_ar_stall();
    arready = 1'b1;
    accept(64'h4FC0, 32'd128);
    step();
    step();
    exp_arid = exp_arid + 4'd1;
    arready = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({arvalid, araddr, arlen, arid, inflight} !== {1'b1, 64'h5000, 8'd0, exp_arid, 2'd1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b addr=%h len=%0d id=%0d inflight=%0d required 1/5000/0/%0d/1",
                 k, arvalid, araddr, arlen, arid, inflight, exp_arid);
      end
    end
    arready     = 1'b1;
    r_last_fire = 1'b1;
    step();
    exp_arid = exp_arid + 4'd1;
    n_checks++;
    if ({arvalid, inflight, err_underflow, done} !== {1'b0, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_same_cycle: got arv=%b inflight=%0d err=%b done=%b required 0/1/0/0",
               arvalid, inflight, err_underflow, done);
    end
    step();
    r_last_fire = 1'b0;
    n_checks++;
    if ({done, inflight} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b inflight=%0d required 1/0", done, inflight);
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    arready = 1'b1;
    accept(64'h8FC0, 32'd128);
    step();
    step();
    arready = 1'b0;
    step();
    n_checks++;
    if ({arvalid, inflight, busy} !== {1'b1, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_pre: got arv=%b inflight=%0d busy=%b required 1/1/1", arvalid, inflight, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_arid = 4'd0;
    n_checks++;
    if ({arvalid, inflight, busy, arid} !== {1'b0, 2'd0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got arv=%b inflight=%0d busy=%b arid=%0d required 0/0/0/0",
               arvalid, inflight, busy, arid);
    end
    arready = 1'b1;
    step();
    r_last_fire = 1'b1;
    step();
    step();
    r_last_fire = 1'b0;
    n_checks++;
    if ({err_underflow, inflight, arvalid, desc_ready} !== {1'b0, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_late_rlast: got err=%b inflight=%0d arv=%b rdy=%b required 0/0/0/1",
               err_underflow, inflight, arvalid, desc_ready);
    end
  endtask

  task automatic test_underflow();
    accept(64'h0, 32'd0);
    step();
    step();
    r_last_fire = 1'b1;
    step();
    r_last_fire = 1'b0;
    n_checks++;
    if ({err_underflow, inflight} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL underflow_set: got err=%b inflight=%0d required 1/0", err_underflow, inflight);
    end
    step();
    step();
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_sticky: got err=%b required 1", err_underflow);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: got err=%b required 0", err_underflow);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    exp_arid       = 4'd0;
    reset          = 1'b1;
    desc_valid     = 1'b0;
    desc_src_addr  = 64'd0;
    desc_len_bytes = 32'd0;
    arready        = 1'b0;
    r_last_fire    = 1'b0;

    test_reset();
    run_two_burst("max_burst", 64'h1000, 32'd8192, 64'h1000, 8'd63, 64'h2000, 8'd63);
    run_two_burst("page_edge", 64'h1FC0, 32'd256,  64'h1FC0, 8'd0,  64'h2000, 8'd2);
    test_zero_len();
    test_credit_limit();
    test_ar_stall();
    test_reset_mid_issue();
    test_underflow();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
